// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message controller: block/digest widths,
// the initial hash value, the controller FSM states and the watchdog default.
package sha256_pkg;

    localparam int unsigned BLK_W          = 512;
    localparam int unsigned DIG_W          = 256;
    localparam int unsigned WDOG_LIMIT_DEF = 80;

    // Initial hash value H(0), H0 in the top word.
    localparam logic [DIG_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // ST_ERR is only reachable when the watchdog is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_OUT  = 3'd3,
        ST_ERR  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/sha256_wdog.sv
// RUN-cycle watchdog for sha256_msg_ctrl. Compiled only when
// SHA256_CTRL_WDOG_EN is defined. The counter clears on load, advances while
// enabled, and expire is high during the LIMIT-th enabled cycle since load.
`ifdef SHA256_CTRL_WDOG_EN
module sha256_wdog
    import sha256_pkg::*;
#(
    parameter int unsigned LIMIT = WDOG_LIMIT_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = enable && (cnt_q == CNT_W'(LIMIT - 1));

    // Next count: clear on load, otherwise count enabled cycles and hold at expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/sha256_msg_ctrl.sv
// Sequencer between a padded-block source and the single-block SHA-256 core.
// Selects IV or chaining value, pulses the core start, captures the first
// core_done of each run and hands the final hash to the digest consumer.
// Optional watchdog (RUN timeout -> sticky ERR): define SHA256_CTRL_WDOG_EN.
module sha256_msg_ctrl
    import sha256_pkg::*;
`ifdef SHA256_CTRL_WDOG_EN
#(
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [BLK_W-1:0] blk_data,
    input  logic             blk_last,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [DIG_W-1:0] dig_data,
    output logic             core_start,
    output logic [DIG_W-1:0] core_h_in,
    output logic [BLK_W-1:0] core_m_in,
    input  logic [DIG_W-1:0] core_h_out,
    input  logic             core_done,
    output logic             busy,
    output logic             err
);

    ctrl_state_e      state_q,      state_d;
    logic             first_q,      first_d;
    logic             last_q,       last_d;
    logic [DIG_W-1:0] chain_q,      chain_d;
    logic [DIG_W-1:0] h_in_q,       h_in_d;
    logic [BLK_W-1:0] m_in_q,       m_in_d;
    logic [DIG_W-1:0] dig_data_q,   dig_data_d;
    logic             core_start_q, core_start_d;
    logic             blk_ready_q,  blk_ready_d;
    logic             dig_valid_q,  dig_valid_d;
    logic             busy_q,       busy_d;

`ifdef SHA256_CTRL_WDOG_EN
    logic err_q, err_d;
    logic wdog_expire;

    sha256_wdog #(
        .LIMIT  (WDOG_LIMIT)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ST_LOAD),
        .enable (state_q == ST_RUN),
        .expire (wdog_expire)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign blk_ready  = blk_ready_q;
    assign dig_valid  = dig_valid_q;
    assign dig_data   = dig_data_q;
    assign core_start = core_start_q;
    assign core_h_in  = h_in_q;
    assign core_m_in  = m_in_q;
    assign busy       = busy_q;

    // Next-state and datapath decisions; all outputs are derived from state_d.
    always_comb begin
        // NOTE: every _d starts from its hold value so no path leaves it unassigned (no latches).
        state_d    = state_q;
        first_d    = first_q;
        last_d     = last_q;
        chain_d    = chain_q;
        h_in_d     = h_in_q;
        m_in_d     = m_in_q;
        dig_data_d = dig_data_q;

        case (state_q)
            ST_IDLE: begin
                if (blk_valid && blk_ready_q) begin
                    m_in_d  = blk_data;
                    h_in_d  = first_q ? SHA256_IV : chain_q;
                    last_d  = blk_last;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Leaving RUN on the first done makes any later wrap pulse irrelevant.
                if (core_done) begin
                    chain_d = core_h_out;
                    if (last_q) begin
                        dig_data_d = core_h_out;
                        first_d    = 1'b1;
                        state_d    = ST_OUT;
                    end else begin
                        first_d    = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
`ifdef SHA256_CTRL_WDOG_EN
                else if (wdog_expire) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_OUT: begin
                if (dig_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SHA256_CTRL_WDOG_EN
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        core_start_d = (state_d == ST_LOAD);
        blk_ready_d  = (state_d == ST_IDLE);
        dig_valid_d  = (state_d == ST_OUT);
        busy_d       = (state_d != ST_IDLE);
`ifdef SHA256_CTRL_WDOG_EN
        err_d        = (state_d == ST_ERR);
`endif
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            first_q      <= 1'b1;
            last_q       <= 1'b0;
            chain_q      <= '0;
            h_in_q       <= '0;
            m_in_q       <= '0;
            dig_data_q   <= '0;
            core_start_q <= 1'b0;
            blk_ready_q  <= 1'b0;
            dig_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SHA256_CTRL_WDOG_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            last_q       <= last_d;
            chain_q      <= chain_d;
            h_in_q       <= h_in_d;
            m_in_q       <= m_in_d;
            dig_data_q   <= dig_data_d;
            core_start_q <= core_start_d;
            blk_ready_q  <= blk_ready_d;
            dig_valid_q  <= dig_valid_d;
            busy_q       <= busy_d;
`ifdef SHA256_CTRL_WDOG_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Self-checking bench for sha256_msg_ctrl with a behavioural SHA-256 core
// (64-cycle run, output_valid on wrap, H_out = H_in + working state).
module tb_sha256_msg_ctrl;
    import sha256_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] blk_data;
    logic             blk_last;
    logic             dig_valid;
    logic             dig_ready;
    logic [DIG_W-1:0] dig_data;
    logic             core_start;
    logic [DIG_W-1:0] core_h_in;
    logic [BLK_W-1:0] core_m_in;
    logic [DIG_W-1:0] core_h_out;
    logic             core_done;
    logic             busy;
    logic             err;

    sha256_msg_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .dig_data   (dig_data),
        .core_start (core_start),
        .core_h_in  (core_h_in),
        .core_m_in  (core_m_in),
        .core_h_out (core_h_out),
        .core_done  (core_done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [BLK_W-1:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [BLK_W-1:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [BLK_W-1:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [BLK_W-1:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [DIG_W-1:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [DIG_W-1:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [DIG_W-1:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // 64 compression rounds without the final feed-forward addition.
    function automatic logic [DIG_W-1:0] sha_rounds(input logic [DIG_W-1:0] h, input logic [BLK_W-1:0] m);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a, b, c, d, e, f, g, hh};
    endfunction

    function automatic logic [DIG_W-1:0] add8(input logic [DIG_W-1:0] x, input logic [DIG_W-1:0] y);
        logic [DIG_W-1:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // Behavioural core: loads on core_start, round 0 next cycle, done when the
    // round counter reaches 64, then wraps and re-asserts done 65 cycles later.
    logic [DIG_W-1:0] work_q;
    int               rnd_q         = 0;
    bit               loaded_q      = 1'b0;
    bit               force_done_lo = 1'b0;

    always @(posedge clk) begin
        if (core_start) begin
            work_q   <= sha_rounds(core_h_in, core_m_in);
            rnd_q    <= 0;
            loaded_q <= 1'b1;
        end else if (loaded_q) begin
            rnd_q    <= (rnd_q == 64) ? 0 : rnd_q + 1;
        end
    end

    assign core_done  = loaded_q && (rnd_q == 64) && !force_done_lo;
    assign core_h_out = add8(core_h_in, work_q);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               checks   = 0;
    int               failures = 0;
    int               hs_cyc   = 0;
    logic [DIG_W-1:0] exp_q [$];
    logic [DIG_W-1:0] h_seen;
    logic [DIG_W-1:0] exp_chain;

    task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block, wait for the handshake, check the LOAD cycle.
    task automatic send_block(input string tag, input logic [BLK_W-1:0] d, input logic l, output logic [DIG_W-1:0] h);
        int n = 0;
        blk_data  = d;
        blk_last  = l;
        blk_valid = 1'b1;
        while (!blk_ready && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, blk_ready, 1'b1);
        hs_cyc = cyc;
        tick();
        blk_valid = 1'b0;
        blk_data  = ~d;
        blk_last  = ~l;
        check({tag, "_start"}, core_start, 1'b1);
        check({tag, "_m_in"}, core_m_in, d);
        h = core_h_in;
        tick();
        check({tag, "_start_pulse"}, core_start, 1'b0);
    endtask

    // Wait for dig_valid, check latency and pop the scoreboard.
    task automatic wait_digest(input string tag);
        int n = 0;
        logic [DIG_W-1:0] e;
        while (!dig_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid_timeout"}, dig_valid, 1'b1);
        if (dig_valid) begin
            check({tag, "_latency"}, cyc - hs_cyc, 67);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_digest"}, dig_data, e);
            end else begin
                check({tag, "_sb_underflow"}, exp_q.size(), 1);
            end
        end
    endtask

    task automatic take_digest();
        dig_ready = 1'b1;
        tick();
        dig_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_last  = 1'b0;
        dig_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_blk_ready", blk_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dig_valid", dig_valid, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_core_h_in", core_h_in, '0);
        check("rst_core_m_in", core_m_in, '0);
        check("rst_dig_data", dig_data, '0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle_blk_ready", blk_ready, 1'b1);
        check("idle_busy", busy, 1'b0);

        // "abc" single block.
        send_block("abc", BLK_ABC, 1'b1, h_seen);
        exp_q.push_back(DIG_ABC);
        check("abc_h_in_iv", h_seen, SHA256_IV);
        check("abc_busy_run", busy, 1'b1);
        wait_digest("abc");
        check("abc_out_blk_ready", blk_ready, 1'b0);
        take_digest();
        check("abc_after_take_valid", dig_valid, 1'b0);

        // Empty message with dig_ready already high.
        dig_ready = 1'b1;
        send_block("empty", BLK_EMPTY, 1'b1, h_seen);
        exp_q.push_back(DIG_EMPTY);
        check("empty_h_in_iv", h_seen, SHA256_IV);
        wait_digest("empty");
        tick();
        check("empty_same_cycle_valid", dig_valid, 1'b0);
        check("empty_same_cycle_ready", blk_ready, 1'b1);
        check("empty_same_cycle_busy", busy, 1'b0);
        dig_ready = 1'b0;

        // Two-block message with a 10-cycle gap.
        send_block("two_b1", BLK_TWO1, 1'b0, h_seen);
        check("two_b1_h_in_iv", h_seen, SHA256_IV);
        for (int i = 0; i < 200 && !blk_ready; i++) tick();
        check("two_b1_ready_latency", cyc - hs_cyc, 67);
        check("two_b1_no_digest", dig_valid, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("two_gap_ready", blk_ready, 1'b1);
        send_block("two_b2", BLK_TWO2, 1'b1, h_seen);
        exp_chain = add8(SHA256_IV, sha_rounds(SHA256_IV, BLK_TWO1));
        check("two_b2_h_in_chain", h_seen, exp_chain);
        exp_q.push_back(DIG_TWO);
        wait_digest("two");
        take_digest();

        // Back-to-back: digest held for 20 cycles while the next block waits.
        send_block("b2b1", BLK_ABC, 1'b1, h_seen);
        exp_q.push_back(DIG_ABC);
        wait_digest("b2b1");
        blk_data  = BLK_EMPTY;
        blk_last  = 1'b1;
        blk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("b2b_out_blk_ready", blk_ready, 1'b0);
            check("b2b_out_dig_valid", dig_valid, 1'b1);
            check("b2b_out_dig_stable", dig_data, DIG_ABC);
            tick();
        end
        take_digest();
        check("b2b_idle_ready", blk_ready, 1'b1);
        send_block("b2b2", BLK_EMPTY, 1'b1, h_seen);
        check("b2b2_h_in_iv", h_seen, SHA256_IV);
        exp_q.push_back(DIG_EMPTY);
        wait_digest("b2b2");
        take_digest();

        // Reset for one cycle at RUN cycle 30, then a fresh "abc".
        send_block("rst_run", BLK_ABC, 1'b1, h_seen);
        for (int i = 0; i < 29; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_dig_valid", dig_valid, 1'b0);
        check("midrst_core_h_in", core_h_in, '0);
        check("midrst_blk_ready", blk_ready, 1'b0);
        tick();
        check("midrst_idle_ready", blk_ready, 1'b1);
        send_block("abc2", BLK_ABC, 1'b1, h_seen);
        check("abc2_h_in_iv", h_seen, SHA256_IV);
        exp_q.push_back(DIG_ABC);
        wait_digest("abc2");
        take_digest();

`ifdef SHA256_CTRL_WDOG_EN
        // Watchdog: core never reports done.
        force_done_lo = 1'b1;
        send_block("wdog", BLK_ABC, 1'b1, h_seen);
        for (int i = 0; i < 79; i++) tick();
        check("wdog_run80_err", err, 1'b0);
        check("wdog_run80_busy", busy, 1'b1);
        tick();
        check("wdog_err", err, 1'b1);
        check("wdog_err_blk_ready", blk_ready, 1'b0);
        check("wdog_err_dig_valid", dig_valid, 1'b0);
        blk_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("wdog_err_sticky", err, 1'b1);
        blk_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("wdog_err_cleared", err, 1'b0);
        force_done_lo = 1'b0;
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
